// File: rtl/vga_sync_gen.sv
// Raster timing source: divides clk into a pixel tick, runs the x/y counters and
// registers sync, blanking, frame strobe and board-cell coordinates from the next position.
module vga_sync_gen #(
  parameter int unsigned H_DISPLAY  = 640,
  parameter int unsigned H_FRONT    = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BACK     = 48,
  parameter int unsigned V_DISPLAY  = 480,
  parameter int unsigned V_FRONT    = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BACK     = 33,
  parameter int unsigned TICK_DIV   = 2,
  parameter int unsigned CELL_SHIFT = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic       ptick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic [5:0] x_div,
  output logic [5:0] y_div,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned TW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [TW-1:0] TickLast = TW'(TICK_DIV - 1);
  localparam logic [9:0]    HLast    = 10'(H_TOTAL - 1);
  localparam logic [9:0]    VLast    = 10'(V_TOTAL - 1);
  localparam logic [9:0]    HVis     = 10'(H_DISPLAY);
  localparam logic [9:0]    VVis     = 10'(V_DISPLAY);
  localparam logic [9:0]    HSyncLo  = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0]    HSyncHi  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0]    VSyncLo  = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0]    VSyncHi  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          adv;
  logic [9:0]    x_nxt, y_nxt;
  logic          vis_nxt, hs_nxt, vs_nxt, fs_nxt;
  logic [5:0]    xd_nxt, yd_nxt;

  always_comb begin
    adv        = (tick_cnt_q == TickLast);
    tick_cnt_d = adv ? '0 : tick_cnt_q + 1'b1;

    x_nxt = pixel_x + 10'd1;
    y_nxt = pixel_y;
    if (pixel_x == HLast) begin
      x_nxt = '0;
      y_nxt = (pixel_y == VLast) ? '0 : pixel_y + 10'd1;
    end

    // Derived outputs come from the next position so they land in step with pixel_x/pixel_y.
    vis_nxt = (x_nxt < HVis) && (y_nxt < VVis);
    hs_nxt  = !((x_nxt >= HSyncLo) && (x_nxt <= HSyncHi));
    vs_nxt  = !((y_nxt >= VSyncLo) && (y_nxt <= VSyncHi));
    xd_nxt  = vis_nxt ? 6'(x_nxt >> CELL_SHIFT) : 6'h3F;
    yd_nxt  = vis_nxt ? 6'(y_nxt >> CELL_SHIFT) : 6'h3F;
    fs_nxt  = adv && (x_nxt == '0) && (y_nxt == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt_q  <= '0;
      ptick       <= 1'b0;
      frame_start <= 1'b0;
      pixel_x     <= HLast;
      pixel_y     <= VLast;
      video_on    <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      x_div       <= 6'h3F;
      y_div       <= 6'h3F;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      ptick       <= adv;
      frame_start <= fs_nxt;
      if (adv) begin
        pixel_x  <= x_nxt;
        pixel_y  <= y_nxt;
        video_on <= vis_nxt;
        hsync    <= hs_nxt;
        vsync    <= vs_nxt;
        x_div    <= xd_nxt;
        y_div    <= yd_nxt;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: default-timing instance for reset/line/cell checks, plus two
// shrunken-raster instances (TICK_DIV=2 and 1) for whole-frame period checks.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Main instance, default 640x480 timing, TICK_DIV=2
  logic       rst_m;
  logic       m_ptick, m_von, m_hs, m_vs, m_fs;
  logic [9:0] m_x, m_y;
  logic [5:0] m_xd, m_yd;

  vga_sync_gen u_main (
    .clk(clk), .rst(rst_m), .ptick(m_ptick), .pixel_x(m_x), .pixel_y(m_y),
    .x_div(m_xd), .y_div(m_yd), .video_on(m_von), .hsync(m_hs), .vsync(m_vs),
    .frame_start(m_fs)
  );

  // Small raster: H 64/4/8/4 (80), V 48/2/2/3 (55)
  logic       rst_s;
  logic       s2_ptick, s2_von, s2_hs, s2_vs, s2_fs;
  logic [9:0] s2_x, s2_y;
  logic [5:0] s2_xd, s2_yd;
  logic       s1_ptick, s1_von, s1_hs, s1_vs, s1_fs;
  logic [9:0] s1_x, s1_y;
  logic [5:0] s1_xd, s1_yd;

  vga_sync_gen #(
    .H_DISPLAY(64), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
    .V_DISPLAY(48), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .TICK_DIV(2), .CELL_SHIFT(4)
  ) u_s2 (
    .clk(clk), .rst(rst_s), .ptick(s2_ptick), .pixel_x(s2_x), .pixel_y(s2_y),
    .x_div(s2_xd), .y_div(s2_yd), .video_on(s2_von), .hsync(s2_hs), .vsync(s2_vs),
    .frame_start(s2_fs)
  );

  vga_sync_gen #(
    .H_DISPLAY(64), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
    .V_DISPLAY(48), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .TICK_DIV(1), .CELL_SHIFT(4)
  ) u_s1 (
    .clk(clk), .rst(rst_s), .ptick(s1_ptick), .pixel_x(s1_x), .pixel_y(s1_y),
    .x_div(s1_xd), .y_div(s1_yd), .video_on(s1_von), .hsync(s1_hs), .vsync(s1_vs),
    .frame_start(s1_fs)
  );

  typedef struct {
    int unsigned n;  // ticks since first visible pixel
    logic [9:0]  x, y;
    logic        von, hs, vs;
    logic [5:0]  xd, yd;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(int unsigned n, int unsigned x, int unsigned y, logic von,
                              logic hs, int unsigned xd, int unsigned yd);
    vec_t v;
    v.n = n; v.x = 10'(x); v.y = 10'(y); v.von = von; v.hs = hs; v.vs = 1'b1;
    v.xd = 6'(xd); v.yd = 6'(yd);
    return v;
  endfunction

  function automatic logic [63:0] m_pack();
    return 64'({m_x, m_y, m_von, m_hs, m_vs, m_xd, m_yd});
  endfunction

  function automatic logic [63:0] reset_pack();
    return 64'({10'd799, 10'd524, 1'b0, 1'b1, 1'b1, 6'h3F, 6'h3F});
  endfunction

  int unsigned cur;
  int          hs_low, ptick_bad, fs_seen;
  int          fs2[$], fs1[$];
  int          v_low, v_bad, s2_coin_bad, s1_ptick_bad, s1_step_bad;
  logic [9:0]  s1_prev;
  logic [11:0] c_a, c_b, c_c, c_d;

  initial begin
    vecs[0]  = mk(0,   0,   0, 1, 1, 0,  0);
    vecs[1]  = mk(15,  15,  0, 1, 1, 0,  0);
    vecs[2]  = mk(16,  16,  0, 1, 1, 1,  0);
    vecs[3]  = mk(624, 624, 0, 1, 1, 39, 0);
    vecs[4]  = mk(639, 639, 0, 1, 1, 39, 0);
    vecs[5]  = mk(640, 640, 0, 0, 1, 63, 63);
    vecs[6]  = mk(655, 655, 0, 0, 1, 63, 63);
    vecs[7]  = mk(656, 656, 0, 0, 0, 63, 63);
    vecs[8]  = mk(751, 751, 0, 0, 0, 63, 63);
    vecs[9]  = mk(752, 752, 0, 0, 1, 63, 63);
    vecs[10] = mk(799, 799, 0, 0, 1, 63, 63);
    vecs[11] = mk(800, 0,   1, 1, 1, 0,  0);
    vecs[12] = mk(816, 16,  1, 1, 1, 1,  0);

    rst_m = 1'b0;
    rst_s = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", m_pack(), reset_pack());
    chk("reset_strobes", 64'({m_ptick, m_fs}), 64'(2'b00));

    @(negedge clk) rst_m = 1'b1;
    @(posedge clk); #1;
    chk("first_edge_hold", 64'({m_ptick, m_x, m_y}), 64'({1'b0, 10'd799, 10'd524}));
    @(posedge clk); #1;
    chk("first_tick_strobes", 64'({m_ptick, m_fs}), 64'(2'b11));
    cur = 0;

    foreach (vecs[i]) begin
      repeat (2 * (vecs[i].n - cur)) @(posedge clk);
      #1;
      cur = vecs[i].n;
      chk($sformatf("vec%0d_x%0d", i, vecs[i].x), m_pack(),
          64'({vecs[i].x, vecs[i].y, vecs[i].von, vecs[i].hs, vecs[i].vs,
               vecs[i].xd, vecs[i].yd}));
    end

    // One full line: tick cadence, hsync width, no stray frame strobe
    hs_low = 0; ptick_bad = 0; fs_seen = 0;
    for (int t = 0; t < 800; t++) begin
      @(posedge clk); #1;
      if (m_ptick !== 1'b0) ptick_bad++;
      if (m_fs) fs_seen++;
      @(posedge clk); #1;
      if (m_ptick !== 1'b1) ptick_bad++;
      if (m_fs) fs_seen++;
      if (!m_hs) hs_low++;
    end
    cur += 800;
    chk("line_hsync_ticks", 64'(hs_low), 64'd96);
    chk("line_ptick_cadence", 64'(ptick_bad), 64'd0);
    chk("line_no_frame_start", 64'(fs_seen), 64'd0);

    // Mid-line reset at (400,2)
    repeat (2 * (400 - 16)) @(posedge clk);
    #1;
    chk("pre_reset_pos", 64'({m_x, m_y}), 64'({10'd400, 10'd2}));
    #2 rst_m = 1'b0;
    #1;
    chk("async_reset_state", m_pack(), reset_pack());
    chk("async_reset_strobes", 64'({m_ptick, m_fs}), 64'(2'b00));
    repeat (3) @(posedge clk);
    #1;
    chk("held_reset_state", m_pack(), reset_pack());
    @(negedge clk) rst_m = 1'b1;
    @(posedge clk); #1;
    chk("rerelease_hold", 64'({m_ptick, m_x, m_y}), 64'({1'b0, 10'd799, 10'd524}));
    @(posedge clk); #1;
    chk("rerelease_first_tick", 64'({m_ptick, m_fs, m_x, m_y, m_von, m_xd, m_yd}),
        64'({1'b1, 1'b1, 10'd0, 10'd0, 1'b1, 6'd0, 6'd0}));

    // Small-raster frames, both divider settings
    v_low = 0; v_bad = 0; s2_coin_bad = 0; s1_ptick_bad = 0; s1_step_bad = 0;
    c_a = 12'hFFF; c_b = 12'hFFF; c_c = 12'h000; c_d = 12'h000;
    s1_prev = '0;
    @(negedge clk) rst_s = 1'b1;
    for (int c = 1; c <= 20000; c++) begin
      @(posedge clk); #1;
      if (s2_fs) fs2.push_back(c);
      if (s1_fs) fs1.push_back(c);
      if (s2_fs && !s2_ptick) s2_coin_bad++;
      if (s2_ptick && fs2.size() == 1) begin
        if (!s2_vs) v_low++;
        if (s2_x == 10'd40 && s2_y == 10'd30) c_a = {s2_xd, s2_yd};
        if (s2_x == 10'd63 && s2_y == 10'd47) c_b = {s2_xd, s2_yd};
        if (s2_x == 10'd64 && s2_y == 10'd47) c_c = {s2_xd, s2_yd};
        if (s2_x == 10'd0  && s2_y == 10'd48) c_d = {s2_xd, s2_yd};
      end
      if (!s2_vs && s2_y != 10'd50 && s2_y != 10'd51) v_bad++;
      if (!s1_ptick) s1_ptick_bad++;
      if (c > 1 && s1_x != ((s1_prev == 10'd79) ? 10'd0 : s1_prev + 10'd1)) s1_step_bad++;
      s1_prev = s1_x;
    end
    chk("s2_frame_count", 64'(fs2.size()), 64'd3);
    chk("s2_first_frame", 64'((fs2.size() > 0) ? fs2[0] : -1), 64'd2);
    chk("s2_frame_period", 64'((fs2.size() > 1) ? fs2[1] - fs2[0] : -1), 64'd8800);
    chk("s2_fs_with_ptick", 64'(s2_coin_bad), 64'd0);
    chk("s2_vsync_ticks", 64'(v_low), 64'd160);
    chk("s2_vsync_lines", 64'(v_bad), 64'd0);
    chk("s2_cell_40_30", 64'(c_a), 64'({6'd2, 6'd1}));
    chk("s2_cell_63_47", 64'(c_b), 64'({6'd3, 6'd2}));
    chk("s2_cell_64_47", 64'(c_c), 64'({6'h3F, 6'h3F}));
    chk("s2_cell_0_48", 64'(c_d), 64'({6'h3F, 6'h3F}));
    chk("s1_frame_count", 64'(fs1.size()), 64'd5);
    chk("s1_first_frame", 64'((fs1.size() > 0) ? fs1[0] : -1), 64'd1);
    chk("s1_frame_period", 64'((fs1.size() > 1) ? fs1[1] - fs1[0] : -1), 64'd4400);
    chk("s1_ptick_high", 64'(s1_ptick_bad), 64'd0);
    chk("s1_step_every_clk", 64'(s1_step_bad), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Raster timing source that sits directly upstream of the VGA data controller.
- Divides the system clock into a pixel tick (ptick) and runs the horizontal and vertical pixel counters.
- Produces active-low hsync/vsync, video_on and a frame_start strobe.
- Reduces the pixel position to board-cell coordinates (x_div, y_div), which the data controller uses to look up game RAM.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- TICK_DIV, 2, clk cycles per pixel (≥1)
- CELL_SHIFT, 4, log2 of cell size in pixels (16×16 cells)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset (0 = reset)
- ptick  out  1  pixel tick, one clk wide, every TICK_DIV clks
- pixel_x  out  10  current horizontal position, 0..H_TOTAL-1
- pixel_y  out  10  current vertical position, 0..V_TOTAL-1
- x_div  out  6  pixel_x >> CELL_SHIFT while visible, else 6'h3F
- y_div  out  6  pixel_y >> CELL_SHIFT while visible, else 6'h3F
- video_on  out  1  1 while pixel_x < H_DISPLAY and pixel_y < V_DISPLAY
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- frame_start  out  1  one-clk pulse when position wraps to (0,0)

Behaviour:
- Derived totals: H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (525).
- All outputs are registered; none are combinational from counters.
- Reset (rst=0, asynchronous):
  - tick_cnt=0, ptick=0, frame_start=0.
  - pixel_x=H_TOTAL-1, pixel_y=V_TOTAL-1.
  - video_on=0, hsync=1, vsync=1, x_div=y_div=6'h3F.
- Reset asserted mid-frame returns all outputs to their reset values immediately; no partial line completes.
- Tick divider:
  - At each clk edge: tick_cnt <= (tick_cnt==TICK_DIV-1) ? 0 : tick_cnt+1.
  - ptick <= (tick_cnt==TICK_DIV-1).
  - TICK_DIV=1 holds ptick at 1 from the first edge after reset.
- Advance: on an edge where tick_cnt==TICK_DIV-1, the position advances in the same edge that raises ptick.
  - Consequence: every output is updated together with ptick and held stable for TICK_DIV clks.
- Horizontal wrap: pixel_x increments; at H_TOTAL-1 it wraps to 0.
- Vertical wrap: pixel_y increments only when pixel_x wraps; at V_TOTAL-1 it wraps to 0.
- First advance after reset: the position wraps to (0,0) and asserts frame_start. The first tick after reset is the first visible pixel.
- Derived outputs are computed from the next-state position and registered in the same edge, giving zero skew against pixel_x/pixel_y:
  - hsync=0 iff next x ∈ [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1] = [656,751].
  - vsync=0 iff next y ∈ [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1] = [490,491].
  - video_on = (next x < H_DISPLAY) && (next y < V_DISPLAY).
  - x_div/y_div = next x/y >> CELL_SHIFT, truncated to 6 bits, when visible; otherwise 6'h3F. Defaults give x_div 0..39, y_div 0..29.
- frame_start is 1 only for the single clk that coincides with ptick on the (V_TOTAL-1, H_TOTAL-1)→(0,0) transition; 0 at all other times.
- Position never holds or skips; exactly one step per ptick.

Test Plan:
1. Reset then release, TICK_DIV=2:
   - During reset: pixel_x=799, pixel_y=524, hsync=vsync=1, x_div=y_div=63, ptick=0.
   - 2nd clk edge after release: ptick=1, frame_start=1, (0,0), video_on=1, x_div=y_div=0.
2. Run one line:
   - ptick pulses every 2 clks.
   - x_div steps 0→1 at pixel_x=16 and reaches 39 at pixel_x=624..639.
   - video_on falls and x_div=63 at pixel_x=640.
   - hsync low exactly for pixel_x 656..751 (96 ticks).
   - pixel_x=799 → next tick 0 with pixel_y+1.
3. Run full frame:
   - Board-cell checks: at (320,240) x_div=20, y_div=15; at (368,336) x_div=23, y_div=21.
   - vsync low for lines 490–491 only.
   - frame_start exactly once per 800×525×2 = 840000 clks.
4. Assert rst at pixel (400,200) for 3 clks: outputs return to reset values asynchronously (before the next clk edge); after release, scenario-1 sequence repeats.
5. TICK_DIV=1 build: ptick=1 continuously after the first edge, position advances every clk, frame period 420000 clks.
